// File: rtl/downcounter_bit_cell.sv
// One stage of the down-counter: a single flop that toggles when borrow_in
// is high, plus the ripple term that propagates the borrow to the next bit.
module downcounter_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic borrow_in,
  input  logic load,
  input  logic load_bit,
  output logic q,
  output logic borrow_out
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_bit;
    end else if (borrow_in) begin
      q_d = ~q_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  // A bit that is already 0 must borrow from the next bit up.
  assign borrow_out = ~q_q & borrow_in;
  assign q          = q_q;

endmodule

// File: rtl/binary_downcounter_reload.sv
// Loadable, cascadable binary down-counter with borrow-out and sticky done.
// Define BINARY_DOWNCOUNTER_AUTO_RELOAD_EN to reload the last loaded value on underflow.
module binary_downcounter_reload #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  output logic [BITS-1:0] out,
  output logic            zero,
  output logic            unf,
  output logic            done
);

  logic [BITS:0]   borrow;
  logic            cell_load;
  logic [BITS-1:0] cell_val;
  logic            done_q;
  logic            done_d;

  // Gating with rst keeps unf low while reset is held, whatever ena does.
  assign borrow[0] = ena & ~load & rst;

`ifdef BINARY_DOWNCOUNTER_AUTO_RELOAD_EN
  logic [BITS-1:0] reload_q;
  logic [BITS-1:0] reload_d;

  always_comb begin
    reload_d = reload_q;
    if (load) begin
      reload_d = load_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end

  // Underflow reuses the cells' load path so the wrap value is replaced.
  assign cell_load = load | borrow[BITS];
  assign cell_val  = load ? load_val : reload_q;
`else
  assign cell_load = load;
  assign cell_val  = load_val;
`endif

  for (genvar i = 0; i < BITS; i++) begin : g_bit
    downcounter_bit_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .borrow_in  (borrow[i]),
      .load       (cell_load),
      .load_bit   (cell_val[i]),
      .q          (out[i]),
      .borrow_out (borrow[i+1])
    );
  end

  always_comb begin
    done_d = done_q;
    if (load) begin
      done_d = 1'b0;
    end else if (borrow[BITS]) begin
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end

  assign unf  = borrow[BITS];
  assign zero = (out == '0);
  assign done = done_q;

endmodule

// File: tb/tb_binary_downcounter_reload.sv
// Self-checking bench for binary_downcounter_reload: vector table plus
// hand sequences for BITS=1, async reset and a two-stage cascade.
module tb_binary_downcounter_reload;

`ifdef BINARY_DOWNCOUNTER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Main 8-bit instance
  logic       ena = 0, load = 0;
  logic [7:0] load_val = 0;
  logic [7:0] out;
  logic       zero, unf, done;

  binary_downcounter_reload #(.BITS(8)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .load(load), .load_val(load_val),
    .out(out), .zero(zero), .unf(unf), .done(done)
  );

  // 1-bit instance
  logic ena1 = 0, load1 = 0;
  logic [0:0] val1 = 0;
  logic [0:0] out1;
  logic zero1, unf1, done1;

  binary_downcounter_reload #(.BITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .ena(ena1), .load(load1), .load_val(val1),
    .out(out1), .zero(zero1), .unf(unf1), .done(done1)
  );

  // Cascade of two 4-bit stages versus an 8-bit reference
  logic       c_ena = 0, c_load = 0;
  logic [7:0] c_val = 0;
  logic [3:0] c_out0, c_out1;
  logic       c_zero0, c_zero1, c_unf0, c_unf1, c_done0, c_done1;
  logic [7:0] r_out;
  logic       r_zero, r_unf, r_done;

  binary_downcounter_reload #(.BITS(4)) u_cas0 (
    .clk(clk), .rst(rst), .ena(c_ena), .load(c_load), .load_val(c_val[3:0]),
    .out(c_out0), .zero(c_zero0), .unf(c_unf0), .done(c_done0)
  );
  binary_downcounter_reload #(.BITS(4)) u_cas1 (
    .clk(clk), .rst(rst), .ena(c_unf0), .load(c_load), .load_val(c_val[7:4]),
    .out(c_out1), .zero(c_zero1), .unf(c_unf1), .done(c_done1)
  );
  binary_downcounter_reload #(.BITS(8)) u_ref (
    .clk(clk), .rst(rst), .ena(c_ena), .load(c_load), .load_val(c_val),
    .out(r_out), .zero(r_zero), .unf(r_unf), .done(r_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       ena;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] exp_pre;
    logic       exp_unf;
    logic [7:0] exp_out;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic e, logic l, logic [7:0] v, logic [7:0] pre,
                              logic u, logic [7:0] o, logic d);
    vec_t r;
    r.ena = e; r.load = l; r.load_val = v; r.exp_pre = pre;
    r.exp_unf = u; r.exp_out = o; r.exp_done = d;
    return r;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    ena = v.ena; load = v.load; load_val = v.load_val;
    #1;
    chk($sformatf("v%0d_pre_out", idx), 32'(out), 32'(v.exp_pre));
    chk($sformatf("v%0d_zero", idx), 32'(zero), 32'(v.exp_pre == 8'd0));
    chk($sformatf("v%0d_unf", idx), 32'(unf), 32'(v.exp_unf));
    @(posedge clk); #1;
    chk($sformatf("v%0d_out", idx), 32'(out), 32'(v.exp_out));
    chk($sformatf("v%0d_done", idx), 32'(done), 32'(v.exp_done));
  endtask

  task automatic step1(input logic e, input logic l, input logic v,
                       input logic pre, input logic u, input logic o, input logic d,
                       input string name);
    @(negedge clk);
    ena1 = e; load1 = l; val1 = v;
    #1;
    chk({name, "_pre"}, 32'(out1), 32'(pre));
    chk({name, "_unf"}, 32'(unf1), 32'(u));
    @(posedge clk); #1;
    chk({name, "_out"}, 32'(out1), 32'(o));
    chk({name, "_done"}, 32'(done1), 32'(d));
  endtask

  initial begin : main
    logic [7:0] wrap5;
    logic [7:0] wrap3;
    logic [7:0] model;
    wrap5 = AUTO ? 8'd5 : 8'd255;
    wrap3 = AUTO ? 8'd3 : 8'd255;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_unf", 32'(unf), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Load 5 and count through underflow
    vecs.push_back(mk(0, 1, 8'd5, 8'd0, 0, 8'd5, 0));
    vecs.push_back(mk(1, 0, 8'd0, 8'd5, 0, 8'd4, 0));
    vecs.push_back(mk(1, 0, 8'd0, 8'd4, 0, 8'd3, 0));
    vecs.push_back(mk(1, 0, 8'd0, 8'd3, 0, 8'd2, 0));
    vecs.push_back(mk(1, 0, 8'd0, 8'd2, 0, 8'd1, 0));
    vecs.push_back(mk(1, 0, 8'd0, 8'd1, 0, 8'd0, 0));
    vecs.push_back(mk(1, 0, 8'd0, 8'd0, 1, wrap5, 1));
    vecs.push_back(mk(1, 0, 8'd0, wrap5, 0, wrap5 - 8'd1, 1));
    // Load beats ena and clears done
    vecs.push_back(mk(1, 1, 8'd9, wrap5 - 8'd1, 0, 8'd9, 0));
    vecs.push_back(mk(0, 1, 8'd0, 8'd9, 0, 8'd0, 0));
    // Load with ena at zero: no underflow
    vecs.push_back(mk(1, 1, 8'd9, 8'd0, 0, 8'd9, 0));
    // Enable gating
    vecs.push_back(mk(0, 1, 8'd3, 8'd9, 0, 8'd3, 0));
    vecs.push_back(mk(1, 0, 8'd0, 8'd3, 0, 8'd2, 0));
    vecs.push_back(mk(0, 0, 8'd0, 8'd2, 0, 8'd2, 0));
    vecs.push_back(mk(0, 0, 8'd0, 8'd2, 0, 8'd2, 0));
    vecs.push_back(mk(1, 0, 8'd0, 8'd2, 0, 8'd1, 0));
    vecs.push_back(mk(1, 0, 8'd0, 8'd1, 0, 8'd0, 0));
    vecs.push_back(mk(1, 0, 8'd0, 8'd0, 1, wrap3, 1));
    vecs.push_back(mk(0, 0, 8'd0, wrap3, 0, wrap3, 1));
    // Arrive at 0x7A for the async reset check
    vecs.push_back(mk(0, 1, 8'h7B, wrap3, 0, 8'h7B, 0));
    vecs.push_back(mk(1, 0, 8'd0, 8'h7B, 0, 8'h7A, 0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Async reset between edges with ena still high
    @(negedge clk);
    ena = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out", 32'(out), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_zero", 32'(zero), 32'd1);
    chk("arst_unf", 32'(unf), 32'd0);
    @(negedge clk);
    ena = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_out", 32'(out), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);

    // BITS=1: 1 -> 0 -> underflow, done sticky across a second underflow
    step1(0, 1, 1, 0, 0, 1, 0, "b1_load");
    step1(1, 0, 0, 1, 0, 0, 0, "b1_c1");
    step1(1, 0, 0, 0, 1, 1, 1, "b1_c2");
    step1(1, 0, 0, 1, 0, 0, 1, "b1_c3");
    step1(1, 0, 0, 0, 1, 1, 1, "b1_c4");

    // Cascade versus 8-bit reference and model
    @(negedge clk);
    c_load = 1'b1; c_val = 8'h00;
    @(negedge clk);
    c_load = 1'b0; c_ena = 1'b1;
    model = 8'h00;
    for (int k = 0; k < 300; k++) begin
      #1;
      chk($sformatf("cas_unf_%0d", k), 32'(c_unf1), 32'(r_unf));
      chk($sformatf("cas_unf_model_%0d", k), 32'(r_unf), 32'(model == 8'd0));
      @(posedge clk); #1;
      model = AUTO ? 8'h00 : model - 8'd1;
      chk($sformatf("cas_vs_ref_%0d", k), 32'({c_out1, c_out0}), 32'(r_out));
      chk($sformatf("cas_vs_model_%0d", k), 32'({c_out1, c_out0}), 32'(model));
      @(negedge clk);
    end
    c_ena = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/binary_downcounter_reload.md
Name: binary_downcounter_reload

Overview:
- Loadable, cascadable binary down-counter; the decrementing counterpart of the team's up-counter.
- Per-bit borrow chain with enable-in and underflow-out, so stages chain into wider counters or prescalers.
- Serves as the timer/prescaler countdown element and as the consumer-side counter that pairs with up-counters.
- Adds a synchronous parallel load and a sticky terminal-count flag.

Parameters:
- BITS, 8, counter width in bits; legal range 1 to 32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- ena  in  1  count enable / borrow-in; decrement by 1 on a clock edge when high.
- load  in  1  synchronous parallel load strobe.
- load_val  in  BITS  value captured on load.
- out  out  BITS  current count (registered).
- zero  out  1  combinational; high when out == 0.
- unf  out  1  combinational underflow / borrow-out; feeds ena of the next stage.
- done  out  1  registered sticky flag; set on underflow, cleared by load.

Behaviour:
- Reset (rst low, asynchronous): out = 0, done = 0, internal reload register = 0. zero = 1 and unf = 0 while reset holds, since ena is don't-care and unf is gated below.
- Borrow chain:
  - b[0] = ena & ~load.
  - b[i+1] = ~out[i] & b[i].
  - Bit i toggles on the clock edge when b[i] is high.
  - unf = b[BITS], i.e. ena & ~load & (out == 0), valid in the same cycle with no register stage.
- Priority: load over ena.
  - load high: out <= load_val; done <= 0; reload register <= load_val.
  - ena is ignored that cycle; unf stays low.
- ena high, load low, out != 0: out <= out - 1; done unchanged.
- ena high, load low, out == 0 (underflow): unf = 1 this cycle; done <= 1 at the edge.
  - Next out depends on AUTO_RELOAD_EN (see below).
- ena low, load low: out and done hold; unf = 0.
- Latency: one edge from ena or load to new out; zero cycles from state/ena to unf and zero.
- Cascading: stage k unf drives stage k+1 ena. The full chain is combinational in one cycle, so a two-stage chain of BITS=4 behaves exactly as one BITS=8 counter.
- BITS=1: the counter toggles 1→0→underflow.
- done stays set across further underflows until the next load or reset.
- Reset asserted mid-count: immediate clear as above; the first edge after release behaves as from reset state.

Optional Feature:
- Macro: BINARY_DOWNCOUNTER_AUTO_RELOAD_EN.
- Defined:
  - On underflow, out <= reload register (last load_val, or 0 after reset).
  - A loaded value N gives a period of N+1 enabled cycles between unf pulses.
- Undefined:
  - No reload register is synthesized.
  - On underflow, out wraps to all-ones (2^BITS - 1); period is 2^BITS.
  - load still writes out.

Decomposition:
- No shared package; no typedefs are needed.
- BITS is the only constant and stays a module parameter.
- One natural sub-module: downcounter_bit_cell, one flip-flop plus borrow logic per bit.
  - Inputs: clk, rst, borrow_in, load, load_bit; outputs: q, borrow_out.
  - Instantiated BITS times in a generate loop.
- Reload and done logic stay in the top level.

Test Plan:
- Reset then idle: rst low 2 cycles, ena=0 → out=0, zero=1, unf=0, done=0.
- BITS=8: load 5, then ena=1 for 7 cycles → out 5,4,3,2,1,0, then 255 without macro or 5 with macro. unf high only in the cycle out=0; done=1 from the following edge.
- Simultaneous events: out=0 with load=1, ena=1, load_val=9 → unf=0, next out=9, done cleared.
- Enable gating: load 3, toggle ena 1,0,0,1,1 → out 3,2,2,2,1,0; out holds when ena=0.
- Cascade: two BITS=4 instances, unf0→ena1, loaded 0x00, ena=1 → combined count 0x00→0xFF without macro; compare against a BITS=8 instance each cycle for 300 cycles.
- Async reset mid-count: assert rst low between clock edges at out=0x7A → out=0 immediately, without waiting for clk; done=0.
